// File: rtl/dp_block_ram_pipe_pkg.sv
// Shared types and constants for the pipelined dual-port block RAM.
package dp_block_ram_pipe_pkg;

    // Clear sequencer states: CLEAR zeroes the array, RUN accepts traffic.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Legal range of read latency (accepted read -> dob_valid).
    localparam int unsigned READ_LAT_MIN = 3;
    localparam int unsigned READ_LAT_MAX = 6;

    // Elaboration-time check of the READ_LAT parameter.
    function automatic bit read_lat_ok(input int unsigned lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/dp_block_ram_pipe_core.sv
// Simple dual-port storage array: one registered write port, one
// registered-address read port. Kept free of reset so it maps onto block RAM.
module dp_ram_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read port; returns the pre-write contents on a same-edge collision.
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dp_block_ram_pipe.sv
// Dual-port block RAM wrapper: clear sequencer, registered write path,
// collision bypass and a READ_LAT-deep read/valid/tag pipeline.
module dp_block_ram_pipe
    import dp_block_ram_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned READ_LAT    = 3,
    parameter int unsigned WRITE_FIRST = 0,
    parameter int unsigned TAG_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  clear_i,
    output logic                  ready_o,
    input  logic                  wea_i,
    input  logic [ADDR_WIDTH-1:0] addra_i,
    input  logic [DATA_WIDTH-1:0] dia_i,
    input  logic                  reb_i,
    input  logic [ADDR_WIDTH-1:0] addrb_i,
    input  logic [TAG_WIDTH-1:0]  tag_in_i,
    output logic [DATA_WIDTH-1:0] dob_o,
    output logic                  dob_valid_o,
    output logic [TAG_WIDTH-1:0]  dob_tag_o
);

    generate
        if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
            $fatal(1, "dp_block_ram_pipe: READ_LAT must be within 3..6");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  wr_acc, rd_acc;
    logic                  wr_en_d, wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_d, wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_d, wr_data_q;

    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [DATA_WIDTH-1:0] core_rdata, rd_data;

    logic [READ_LAT:1]     vld_q;
    logic [DATA_WIDTH-1:0] dat_q [READ_LAT:3];
    logic [TAG_WIDTH-1:0]  tag_q [READ_LAT:1];

    // Ready is also held low combinationally while reset is asserted.
    assign ready_o = resetn_i && (state_q == ST_RUN);
    assign wr_acc  = ready_o && wea_i;
    assign rd_acc  = ready_o && reb_i;

    // Clear sequencer state register.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sequencer next state: sweep every address once, then run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (&cnt_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Write request mux: the clear sweep shares the registered write path.
    always_comb begin
        wr_en_d   = wr_acc;
        wr_addr_d = addra_i;
        wr_data_d = dia_i;
        if (state_q == ST_CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = '0;
        end
    end

    // Write enable register; reset drops a pending write.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) wr_en_q <= 1'b0;
        else           wr_en_q <= wr_en_d;
    end

    // Unreset datapath: write address/data, read address, bypass capture.
    always_ff @(posedge clk_i) begin
        wr_addr_q  <= wr_addr_d;
        wr_data_q  <= wr_data_d;
        rd_addr_q  <= addrb_i;
        byp_q      <= (WRITE_FIRST != 0) && wr_en_q && (wr_addr_q == rd_addr_q);
        byp_data_q <= wr_data_q;
    end

    dp_ram_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_core (
        .clk_i   (clk_i),
        .we_i    (wr_en_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .re_i    (vld_q[1]),
        .raddr_i (rd_addr_q),
        .rdata_o (core_rdata)
    );

    // Write-first: a same-cycle write to the read address overrides the array.
    assign rd_data = byp_q ? byp_data_q : core_rdata;

    // Valid/tag/data pipeline; the output stage only loads on valid so dob holds.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            vld_q <= '0;
            for (int k = 3; k <= READ_LAT; k++) dat_q[k] <= '0;
            for (int k = 1; k <= READ_LAT; k++) tag_q[k] <= '0;
        end else begin
            vld_q    <= {vld_q[READ_LAT-1:1], rd_acc};
            tag_q[1] <= tag_in_i;
            for (int k = 2; k <= READ_LAT; k++) begin
                if (k < READ_LAT || vld_q[k-1]) tag_q[k] <= tag_q[k-1];
            end
            for (int k = 3; k <= READ_LAT; k++) begin
                if (k < READ_LAT || vld_q[k-1])
                    dat_q[k] <= (k == 3) ? rd_data : dat_q[(k == 3) ? 3 : k - 1];
            end
        end
    end

    assign dob_o       = dat_q[READ_LAT];
    assign dob_tag_o   = tag_q[READ_LAT];
    assign dob_valid_o = vld_q[READ_LAT];

endmodule

// File: tb/tb_dp_block_ram_pipe.sv
// Bench for dp_block_ram_pipe: two instances (read-first/latency 3 and
// write-first/latency 6) share one stimulus stream and a behavioural model.
module tb_dp_block_ram_pipe;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int TW    = 8;
    localparam int DEPTH = 16;
    localparam int LAT_A = 3;
    localparam int LAT_B = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0, clear = 1'b0, wea = 1'b0, reb = 1'b0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [DW-1:0] dia = '0;
    logic [TW-1:0] tag_in = '0;

    logic          ready_a, dob_valid_a, ready_b, dob_valid_b;
    logic [DW-1:0] dob_a, dob_b;
    logic [TW-1:0] dob_tag_a, dob_tag_b;

    always #5 clk = ~clk;

    dp_block_ram_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(LAT_A), .WRITE_FIRST(0), .TAG_WIDTH(TW)
    ) u_dut_a (
        .clk_i(clk), .resetn_i(resetn), .clear_i(clear), .ready_o(ready_a),
        .wea_i(wea), .addra_i(addra), .dia_i(dia),
        .reb_i(reb), .addrb_i(addrb), .tag_in_i(tag_in),
        .dob_o(dob_a), .dob_valid_o(dob_valid_a), .dob_tag_o(dob_tag_a)
    );

    dp_block_ram_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(LAT_B), .WRITE_FIRST(1), .TAG_WIDTH(TW)
    ) u_dut_b (
        .clk_i(clk), .resetn_i(resetn), .clear_i(clear), .ready_o(ready_b),
        .wea_i(wea), .addra_i(addra), .dia_i(dia),
        .reb_i(reb), .addrb_i(addrb), .tag_in_i(tag_in),
        .dob_o(dob_b), .dob_valid_o(dob_valid_b), .dob_tag_o(dob_tag_b)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            due;
    } exp_t;

    exp_t          qa[$], qb[$];
    logic [DW-1:0] mem [DEPTH];
    bit            m_run = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] hold_a = '0, hold_b = '0;
    logic [TW-1:0] htag_a = '0, htag_b = '0;

    int  n_chk = 0, n_pass = 0;
    int  cyc_n = 0, rel_cyc = 0, rise_cyc = -1;
    bit  chk_on = 1'b0, last_ready = 1'b0;
    int  cnt_va = 0, cnt_vb = 0;
    int  last_a_cyc = 0, last_b_cyc = 0;
    logic [DW-1:0] last_a_data = '0, last_b_data = '0, or_a = '0, or_b = '0;
    logic [TW-1:0] last_a_tag = '0, last_b_tag = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic mon_a();
        logic ev;
        ev = (qa.size() > 0) && (qa[0].due == cyc_n);
        chk("a_valid", 64'(dob_valid_a), 64'(ev));
        if (ev) begin
            hold_a = qa[0].data;
            htag_a = qa[0].tag;
            void'(qa.pop_front());
        end
        if (dob_valid_a) begin
            cnt_va++;
            last_a_data = dob_a;
            last_a_tag  = dob_tag_a;
            last_a_cyc  = cyc_n;
            or_a        = or_a | dob_a;
        end
        chk("a_dob", 64'(dob_a), 64'(hold_a));
        chk("a_tag", 64'(dob_tag_a), 64'(htag_a));
    endtask

    task automatic mon_b();
        logic ev;
        ev = (qb.size() > 0) && (qb[0].due == cyc_n);
        chk("b_valid", 64'(dob_valid_b), 64'(ev));
        if (ev) begin
            hold_b = qb[0].data;
            htag_b = qb[0].tag;
            void'(qb.pop_front());
        end
        if (dob_valid_b) begin
            cnt_vb++;
            last_b_data = dob_b;
            last_b_tag  = dob_tag_b;
            last_b_cyc  = cyc_n;
            or_b        = or_b | dob_b;
        end
        chk("b_dob", 64'(dob_b), 64'(hold_b));
        chk("b_tag", 64'(dob_tag_b), 64'(htag_b));
    endtask

    // One clock: drive at negedge, check outputs, then advance the model at posedge.
    task automatic cyc(input logic rst_n, input logic clr, input logic we, input int wa,
                       input logic [DW-1:0] wd, input logic re, input int ra,
                       input logic [TW-1:0] tg);
        @(negedge clk);
        resetn = rst_n; clear = clr; wea = we; addra = wa[AW-1:0]; dia = wd;
        reb = re; addrb = ra[AW-1:0]; tag_in = tg;
        #1;
        last_ready = ready_a;
        if (ready_a && rise_cyc < 0) rise_cyc = cyc_n;
        if (chk_on) begin
            chk("ready_a", 64'(ready_a), 64'(m_run && rst_n));
            chk("ready_b", 64'(ready_b), 64'(m_run && rst_n));
            mon_a();
            mon_b();
        end
        @(posedge clk);
        if (!rst_n) begin
            m_run = 1'b0; m_cnt = 0;
            qa.delete(); qb.delete();
            hold_a = '0; hold_b = '0; htag_a = '0; htag_b = '0;
            rel_cyc = cyc_n + 1; rise_cyc = -1;
        end else if (!m_run) begin
            mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) m_run = 1'b1;
        end else begin
            if (re) begin
                logic [DW-1:0] old;
                old = mem[ra % DEPTH];
                qa.push_back('{data: old, tag: tg, due: cyc_n + LAT_A});
                qb.push_back('{data: (we && (wa % DEPTH) == (ra % DEPTH)) ? wd : old,
                               tag: tg, due: cyc_n + LAT_B});
            end
            if (we) mem[wa % DEPTH] = wd;
            if (clr) begin
                m_run = 1'b0;
                m_cnt = 0;
            end
        end
        cyc_n++;
        chk_on = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && rise_cyc < 0; i++) idle(1);
        chk("ready_rise", 64'(rise_cyc - rel_cyc), 64'(DEPTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, c0a, c0b, low;

        // Reset and initial clear sweep.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0, '0);
        chk("rst_ready", 64'(ready_a), 64'(0));
        chk("rst_dob", 64'(dob_a), 64'(0));
        wait_ready();

        // Every address reads zero after the sweep.
        c0a = cnt_va; c0b = cnt_vb;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, i, TW'(i));
        idle(8);
        chk("zero_cnt_a", 64'(cnt_va - c0a), 64'(DEPTH));
        chk("zero_cnt_b", 64'(cnt_vb - c0b), 64'(DEPTH));
        chk("zero_or_a", 64'(or_a), 64'(0));
        chk("zero_or_b", 64'(or_b), 64'(0));

        // Write then read next cycle: data, tag and exact latency.
        cyc(1'b1, 1'b0, 1'b1, 3, 32'hA5A5_0001, 1'b0, 0, '0);
        n0 = cyc_n;
        cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 3, 8'h07);
        idle(8);
        chk("wr_rd_a", 64'(last_a_data), 64'h0000_0000_A5A5_0001);
        chk("wr_rd_b", 64'(last_b_data), 64'h0000_0000_A5A5_0001);
        chk("tag_a", 64'(last_a_tag), 64'h07);
        chk("tag_b", 64'(last_b_tag), 64'h07);
        chk("lat_a", 64'(last_a_cyc - n0), 64'(3));
        chk("lat_b", 64'(last_b_cyc - n0), 64'(6));

        // Same-cycle collision at address 5 holding 1, writing 2.
        cyc(1'b1, 1'b0, 1'b1, 5, 32'h1, 1'b0, 0, '0);
        cyc(1'b1, 1'b0, 1'b1, 5, 32'h2, 1'b1, 5, 8'h15);
        idle(8);
        chk("coll_rf", 64'(last_a_data), 64'h1);
        chk("coll_wf", 64'(last_b_data), 64'h2);
        cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 5, 8'h16);
        idle(8);
        chk("coll_after_a", 64'(last_a_data), 64'h2);

        // Streaming: read and write every cycle, collisions every 8th cycle.
        c0a = cnt_va; c0b = cnt_vb;
        for (int i = 0; i < 256; i++)
            cyc(1'b1, 1'b0, 1'b1, (i * 5) % DEPTH, {16'hC0DE, i[15:0]}, 1'b1, (i * 7) % DEPTH, i[7:0]);
        idle(8);
        chk("stream_cnt_a", 64'(cnt_va - c0a), 64'(256));
        chk("stream_cnt_b", 64'(cnt_vb - c0b), 64'(256));

        // Clear request with a read of 9 and a write of 2 in the same cycle.
        cyc(1'b1, 1'b0, 1'b1, 9, 32'h55, 1'b0, 0, '0);
        cyc(1'b1, 1'b1, 1'b1, 2, 32'h77, 1'b1, 9, 8'h99);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, i == 12, 9, 32'hDEAD, i == 12, 9, 8'h3C);
            if (last_ready) break;
            low++;
        end
        chk("clr_low", 64'(low), 64'(DEPTH));
        chk("clr_pre_a", 64'(last_a_data), 64'h55);
        chk("clr_pre_b", 64'(last_b_data), 64'h55);
        chk("clr_pre_tag", 64'(last_a_tag), 64'h99);
        cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 9, 8'h09);
        idle(8);
        chk("clr_9_a", 64'(last_a_data), 64'(0));
        chk("clr_9_b", 64'(last_b_data), 64'(0));
        cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 2, 8'h02);
        idle(8);
        chk("clr_2_a", 64'(last_a_data), 64'(0));

        // One-cycle reset with two reads in flight.
        cyc(1'b1, 1'b0, 1'b1, 4, 32'h44, 1'b0, 0, '0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 4, 8'hE1);
        cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 4, 8'hE2);
        c0a = cnt_va; c0b = cnt_vb;
        cyc(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0, '0);
        #1;
        chk("rst2_dob_a", 64'(dob_a), 64'(0));
        chk("rst2_dob_b", 64'(dob_b), 64'(0));
        chk("rst2_vld_b", 64'(dob_valid_b), 64'(0));
        wait_ready();
        chk("rst2_drop_a", 64'(cnt_va - c0a), 64'(0));
        chk("rst2_drop_b", 64'(cnt_vb - c0b), 64'(0));
        cyc(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 4, 8'h04);
        idle(8);
        chk("rst2_4_a", 64'(last_a_data), 64'(0));
        chk("rst2_4_b", 64'(last_b_data), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dp_block_ram_pipe.md
# dp_block_ram_pipe

Parametrised simple dual-port block RAM for the channelizer datapath. Port A writes, port B reads, with configurable read latency, a selectable collision mode and a read-valid/tag sideband. A built-in clear sequencer zeroes the whole array after reset or on request. It serves as the common storage primitive for per-channel state, coefficient and delay-line memories.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH
- READ_LAT, 3, cycles from accepted read to dob_valid; legal 3..6
- WRITE_FIRST, 0, collision mode: 0 = read-first (old data), 1 = write-first (new data)
- TAG_WIDTH, 8, sideband carried with each read (e.g. channel index)
- clk  in  1  sole clock
- resetn  in  1  synchronous, active-low reset
- clear  in  1  single-cycle request to zero the whole RAM
- ready  out  1  high when reads and writes are accepted
- wea  in  1  write enable, accepted when ready
- addra  in  ADDR_WIDTH  write address
- dia  in  DATA_WIDTH  write data
- reb  in  1  read enable, accepted when ready
- addrb  in  ADDR_WIDTH  read address
- tag_in  in  TAG_WIDTH  sideband captured with the read
- dob  out  DATA_WIDTH  read data
- dob_valid  out  1  dob and dob_tag valid this cycle
- dob_tag  out  TAG_WIDTH  tag_in of the corresponding read

## Operation
- States: CLEAR, RUN. Reset forces CLEAR with clear counter = 0.
- CLEAR: writes 0 to address cnt each cycle, cnt 0..DEPTH-1; after the write to DEPTH-1, go to RUN. ready = 0 in CLEAR and during reset.
- RUN: ready = 1. clear = 1 in RUN -> CLEAR next cycle, cnt = 0. clear during CLEAR is ignored (no restart).
- wea/reb while ready = 0: ignored; no write, no dob_valid.
- Write path: request registered once (addra_d, dia_d, wea_d), then written to the array. The clear sequencer drives the same registered write path.
- Read path: stage 1 registers addrb and tag; stage 2 reads the array; stages 3..READ_LAT are register pipeline. valid and tag travel in a parallel shift register.
- Ordering, relative to input ports: a read at cycle t sees every write accepted at cycles < t.
- Collision, with write and read accepted in the same cycle to the same address: WRITE_FIRST = 0 returns old data; WRITE_FIRST = 1 returns dia via a bypass mux (compare addra_d == addrb_d with wea_d).
- Clear vs in-flight traffic: writes and reads accepted in the clear-request cycle complete first. Such reads return pre-clear contents. Such a write lands, then gets zeroed.
- Reset mid-operation clears valid pipeline, wea_d and dob_valid. In-flight reads are dropped. A write accepted in the cycle before resetn falls may be lost. RAM contents are then rezeroed by CLEAR.

## Timing
- Reset values: ready = 0, dob_valid = 0, dob = 0, dob_tag = 0.
- First cycle with resetn sampled high = cycle 0. CLEAR writes cycles 0..DEPTH-1. ready = 1 from cycle DEPTH.
- clear sampled at cycle t (RUN): ready = 0 cycles t+1..t+DEPTH, ready = 1 at t+DEPTH+1.
- Read accepted at cycle t: dob_valid = 1 at cycle t+READ_LAT.
- Throughput: one read and one write per cycle, back-to-back, any addresses.
- dob and dob_tag hold their last value when dob_valid = 0.

## Structure
- Shared package holds state enum (CLEAR, RUN), READ_LAT range constants (min 3, max 6) and an elaboration-time parameter check.
- One sub-module, dp_ram_core: registered-address array read plus write port with ram_style = "block". The wrapper owns the clear FSM, bypass mux, latency pipeline and valid/tag pipeline.

## Test plan
- Reset release with ADDR_WIDTH = 4 -> ready rises exactly at cycle 16; reads of all addresses return 0.
- Write 0xA5A5_0001 to address 3, read address 3 next cycle with tag 0x07 -> dob = 0xA5A5_0001, dob_tag = 0x07, dob_valid exactly READ_LAT cycles later. Repeat for READ_LAT = 3 and 6.
- Same-cycle write 0x2 / read at address 5 holding 0x1 -> 0x1 when WRITE_FIRST = 0, 0x2 when WRITE_FIRST = 1.
- Streaming 256 back-to-back reads interleaved with writes -> dob_valid is continuous and data/tags match a scoreboard model.
- clear pulse with a read of address 9 (holding 0x55) in the same cycle -> that read returns 0x55; ready low for DEPTH cycles; then address 9 reads 0; wea while ready = 0 has no effect.
- resetn low for 1 cycle with 2 reads in flight -> no dob_valid for those reads; dob = 0; CLEAR restarts from address 0.
